// File: rtl/cpu_ctrl.sv
// Multi-cycle control sequencer for the 16-bit CPU: fetches over a req/ack port,
// decodes the CR16-style encoding and drives the reg_alu datapath controls.
module cpu_ctrl (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] mem_addr,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   input  logic [15:0] dSrc,
   input  logic [15:0] dDst,
   input  logic [4:0]  psr,
   output logic        write,
   output logic        IMM_MUX,
   output logic        wb_mem,
   output logic [3:0]  rSrc,
   output logic [3:0]  rDst,
   output logic [4:0]  aluOp,
   output logic [15:0] pc,
   output logic [15:0] imm,
   output logic [15:0] mem_data,
   output logic        illegal
);

   localparam logic [4:0] ALUOP_AND = 5'b00001;
   localparam logic [4:0] ALUOP_OR  = 5'b00010;
   localparam logic [4:0] ALUOP_XOR = 5'b00011;
   localparam logic [4:0] ALUOP_ADD = 5'b00101;
   localparam logic [4:0] ALUOP_SUB = 5'b01001;
   localparam logic [4:0] ALUOP_CMP = 5'b01011;
   localparam logic [4:0] ALUOP_MOV = 5'b01101;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   function automatic logic alu_code_ok(input logic [3:0] code);
      case (code)
         4'b0101, 4'b1001, 4'b1011, 4'b0001,
         4'b0010, 4'b0011, 4'b1101: alu_code_ok = 1'b1;
         default:                   alu_code_ok = 1'b0;
      endcase
   endfunction

   function automatic logic [4:0] alu_op_of(input logic [3:0] code);
      case (code)
         4'b0101: alu_op_of = ALUOP_ADD;
         4'b1001: alu_op_of = ALUOP_SUB;
         4'b1011: alu_op_of = ALUOP_CMP;
         4'b0001: alu_op_of = ALUOP_AND;
         4'b0010: alu_op_of = ALUOP_OR;
         4'b0011: alu_op_of = ALUOP_XOR;
         4'b1101: alu_op_of = ALUOP_MOV;
         default: alu_op_of = 5'b00000;
      endcase
   endfunction

   // Logical immediates are zero-extended; everything else sign-extends imm8.
   function automatic logic [15:0] imm_of(input logic [15:0] word);
      case (word[15:12])
         4'b0001, 4'b0010, 4'b0011: imm_of = {8'h00, word[7:0]};
         default:                   imm_of = {{8{word[7]}}, word[7:0]};
      endcase
   endfunction

   // flags = {N,Z,F,L,C}
   function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] flags);
      case (cond)
         4'b0000: cond_true = flags[3];
         4'b0001: cond_true = ~flags[3];
         4'b0110: cond_true = flags[4];
         4'b0111: cond_true = ~flags[4];
         4'b0010: cond_true = flags[0];
         4'b0011: cond_true = ~flags[0];
         4'b1110: cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   endfunction

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic        write_q, write_d;
   logic        imm_mux_q, imm_mux_d;
   logic        wb_mem_q, wb_mem_d;
   logic [3:0]  rsrc_q, rsrc_d;
   logic [3:0]  rdst_q, rdst_d;
   logic [4:0]  aluop_q, aluop_d;
   logic [15:0] imm_q, imm_d;
   logic [15:0] mem_data_q, mem_data_d;
   logic        illegal_q, illegal_d;

   logic is_alu, is_cmp, is_load, is_stor, is_jcond, is_bcond, is_legal, taken;

   // dDst goes to memory through the datapath; the F and L flags feed no condition.
   logic unused_inputs;
   assign unused_inputs = ^{dDst, psr[2:1]};

   // Instruction class of the latched ir.
   always_comb begin
      is_alu   = ((ir_q[15:12] == 4'b0000) && alu_code_ok(ir_q[7:4])) || alu_code_ok(ir_q[15:12]);
      is_cmp   = ((ir_q[15:12] == 4'b0000) && (ir_q[7:4] == 4'b1011)) || (ir_q[15:12] == 4'b1011);
      is_load  = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b0000);
      is_stor  = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b0100);
      is_jcond = (ir_q[15:12] == 4'b0100) && (ir_q[7:4] == 4'b1100);
      is_bcond = (ir_q[15:12] == 4'b1100);
      is_legal = is_alu || is_load || is_stor || is_jcond || is_bcond;
      taken    = cond_true(ir_q[11:8], psr);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      mem_we_d   = mem_we_q;
      write_d    = 1'b0;
      wb_mem_d   = 1'b0;
      illegal_d  = 1'b0;
      imm_mux_d  = imm_mux_q;
      rsrc_d     = rsrc_q;
      rdst_d     = rdst_q;
      aluop_d    = aluop_q;
      imm_d      = imm_q;
      mem_data_d = mem_data_q;
      case (state_q)
         S_FETCH: begin
            // Coming out of reset the request is still low; raise it first.
            if (!mem_req_q) begin
               mem_req_d  = 1'b1;
               mem_addr_d = pc_q;
               mem_we_d   = 1'b0;
            end else if (mem_ack) begin
               ir_d      = mem_rdata;
               mem_req_d = 1'b0;
               rsrc_d    = mem_rdata[3:0];
               rdst_d    = mem_rdata[11:8];
               imm_d     = imm_of(mem_rdata);
               imm_mux_d = alu_code_ok(mem_rdata[15:12]);
               if (mem_rdata[15:12] == 4'b0000) begin
                  aluop_d = alu_op_of(mem_rdata[7:4]);
               end else begin
                  aluop_d = alu_op_of(mem_rdata[15:12]);
               end
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            write_d   = is_alu && !is_cmp;
            illegal_d = !is_legal;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            if (is_load || is_stor) begin
               mem_req_d  = 1'b1;
               mem_addr_d = dSrc;
               mem_we_d   = is_stor;
               state_d    = S_MEM;
            end else begin
               if (is_jcond && taken) begin
                  pc_d = dSrc;
               end else if (is_bcond && taken) begin
                  pc_d = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
               end else begin
                  pc_d = pc_q + 16'd1;
               end
               mem_req_d  = 1'b1;
               mem_addr_d = pc_d;
               mem_we_d   = 1'b0;
               state_d    = S_FETCH;
            end
         end
         S_MEM: begin
            if (mem_ack && is_load) begin
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_data_d = mem_rdata;
               wb_mem_d   = 1'b1;
               write_d    = 1'b1;
               state_d    = S_WB;
            end else if (mem_ack) begin
               pc_d       = pc_q + 16'd1;
               mem_req_d  = 1'b1;
               mem_addr_d = pc_d;
               mem_we_d   = 1'b0;
               state_d    = S_FETCH;
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB: begin
            pc_d       = pc_q + 16'd1;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_d;
            mem_we_d   = 1'b0;
            state_d    = S_FETCH;
         end
         default: begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            state_d   = S_FETCH;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         pc_q       <= 16'h0000;
         ir_q       <= 16'h0000;
         mem_addr_q <= 16'h0000;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         write_q    <= 1'b0;
         imm_mux_q  <= 1'b0;
         wb_mem_q   <= 1'b0;
         rsrc_q     <= 4'h0;
         rdst_q     <= 4'h0;
         aluop_q    <= 5'b00000;
         imm_q      <= 16'h0000;
         mem_data_q <= 16'h0000;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         write_q    <= write_d;
         imm_mux_q  <= imm_mux_d;
         wb_mem_q   <= wb_mem_d;
         rsrc_q     <= rsrc_d;
         rdst_q     <= rdst_d;
         aluop_q    <= aluop_d;
         imm_q      <= imm_d;
         mem_data_q <= mem_data_d;
         illegal_q  <= illegal_d;
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign write    = write_q;
   assign IMM_MUX  = imm_mux_q;
   assign wb_mem   = wb_mem_q;
   assign rSrc     = rsrc_q;
   assign rDst     = rdst_q;
   assign aluOp    = aluop_q;
   assign pc       = pc_q;
   assign imm      = imm_q;
   assign mem_data = mem_data_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl: instruction stream with hand-computed
// pc, decode fields, memory handshakes and reset-during-MEM behaviour.
module tb_cpu_ctrl;

   logic        clk;
   logic        reset;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] dSrc;
   logic [15:0] dDst;
   logic [4:0]  psr;
   logic        write;
   logic        IMM_MUX;
   logic        wb_mem;
   logic [3:0]  rSrc;
   logic [3:0]  rDst;
   logic [4:0]  aluOp;
   logic [15:0] pc;
   logic [15:0] imm;
   logic [15:0] mem_data;
   logic        illegal;

   int total = 0;
   int bad   = 0;

   logic [15:0] d_imm;
   logic        d_mux;
   logic [3:0]  d_src;
   logic [3:0]  d_dst;
   logic [4:0]  d_alu;

   cpu_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .mem_addr  (mem_addr),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .dSrc      (dSrc),
      .dDst      (dDst),
      .psr       (psr),
      .write     (write),
      .IMM_MUX   (IMM_MUX),
      .wb_mem    (wb_mem),
      .rSrc      (rSrc),
      .rDst      (rDst),
      .aluOp     (aluOp),
      .pc        (pc),
      .imm       (imm),
      .mem_data  (mem_data),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Runs one 3-cycle instruction starting from a FETCH cycle with mem_req high.
   task automatic exec3(input logic [15:0] instr, input logic exp_wr, input logic exp_ill,
                        input logic [15:0] exp_pc);
      mem_rdata = instr;
      tick();
      d_imm = imm; d_mux = IMM_MUX; d_src = rSrc; d_dst = rDst; d_alu = aluOp;
      check("dec_write", write, 16'd0);
      check("dec_req", mem_req, 16'd0);
      tick();
      check("ex_write", write, exp_wr);
      check("ex_illegal", illegal, exp_ill);
      tick();
      check("pc", pc, exp_pc);
      check("fetch_req", mem_req, 16'd1);
      check("fetch_addr", mem_addr, exp_pc);
      check("post_write", write, 16'd0);
      check("post_illegal", illegal, 16'd0);
   endtask

   initial begin
      reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h5103;
      dSrc = 16'h0000; dDst = 16'h0000; psr = 5'b00000;
      tick(); tick();
      check("rst_req", mem_req, 16'd0);
      check("rst_pc", pc, 16'h0000);
      check("rst_write", write, 16'd0);
      check("rst_imm", imm, 16'h0000);
      check("rst_alu", aluOp, 16'd0);
      reset = 1'b0;
      tick();
      check("first_req", mem_req, 16'd1);
      check("first_addr", mem_addr, 16'h0000);

      // ADDI r1,#3
      exec3(16'h5103, 1'b1, 1'b0, 16'h0001);
      check("addi_imm", d_imm, 16'h0003);
      check("addi_mux", d_mux, 16'd1);
      check("addi_rdst", d_dst, 16'd1);
      check("addi_alu", d_alu, 16'b00101);
      // ADD r2,r3
      exec3(16'h0253, 1'b1, 1'b0, 16'h0002);
      check("add_alu", d_alu, 16'b00101);
      check("add_mux", d_mux, 16'd0);
      check("add_rsrc", d_src, 16'd3);
      check("add_rdst", d_dst, 16'd2);
      // CMP r2,r3: no write
      exec3(16'h02B3, 1'b0, 1'b0, 16'h0003);
      check("cmp_alu", d_alu, 16'b01011);
      // ANDI r3,#F0: zero-extended
      exec3(16'h13F0, 1'b1, 1'b0, 16'h0004);
      check("andi_imm", d_imm, 16'h00F0);
      check("andi_alu", d_alu, 16'b00001);
      check("andi_mux", d_mux, 16'd1);

      // LOAD r1,[r5] with two wait cycles
      mem_rdata = 16'h4105; dSrc = 16'h0040;
      tick();
      check("ld_dec_write", write, 16'd0);
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ld_req", mem_req, 16'd1);
         check("ld_addr", mem_addr, 16'h0040);
         check("ld_we", mem_we, 16'd0);
         check("ld_write", write, 16'd0);
         if (i == 2) begin
            mem_ack = 1'b1; mem_rdata = 16'h1234;
         end
      end
      tick();
      check("wb_mem", wb_mem, 16'd1);
      check("wb_write", write, 16'd1);
      check("wb_data", mem_data, 16'h1234);
      check("wb_req", mem_req, 16'd0);
      mem_rdata = 16'h4245; dSrc = 16'h0050; dDst = 16'hBEEF;
      tick();
      check("ld_pc", pc, 16'h0005);
      check("ld_post_write", write, 16'd0);
      check("ld_post_wbmem", wb_mem, 16'd0);
      check("ld_post_addr", mem_addr, 16'h0005);

      // STOR [r5],r2
      tick();
      check("st_dec_write", write, 16'd0);
      tick();
      check("st_ex_write", write, 16'd0);
      tick();
      check("st_we", mem_we, 16'd1);
      check("st_req", mem_req, 16'd1);
      check("st_addr", mem_addr, 16'h0050);
      check("st_write", write, 16'd0);
      tick();
      check("st_pc", pc, 16'h0006);
      check("st_post_we", mem_we, 16'd0);
      check("st_post_write", write, 16'd0);

      // Jumps and branches
      dSrc = 16'h0010;
      exec3(16'h4FC0, 1'b0, 1'b0, 16'h0007);
      exec3(16'h4EC0, 1'b0, 1'b0, 16'h0010);
      psr = 5'b01000;
      exec3(16'hC0FE, 1'b0, 1'b0, 16'h000E);
      exec3(16'h4EC0, 1'b0, 1'b0, 16'h0010);
      psr = 5'b00000;
      exec3(16'hC0FE, 1'b0, 1'b0, 16'h0011);
      exec3(16'h7000, 1'b0, 1'b1, 16'h0012);
      exec3(16'hCEED, 1'b0, 1'b0, 16'hFFFF);
      // SUBI at 0xFFFF wraps pc to 0
      exec3(16'h9280, 1'b1, 1'b0, 16'h0000);
      check("subi_imm", d_imm, 16'hFF80);
      check("subi_alu", d_alu, 16'b01001);
      exec3(16'h5103, 1'b1, 1'b0, 16'h0001);

      // Reset while MEM waits for ack
      mem_rdata = 16'h4105; dSrc = 16'h0040;
      tick();
      tick();
      mem_ack = 1'b0;
      tick();
      check("rm_req_before", mem_req, 16'd1);
      reset = 1'b1;
      tick();
      check("rm_req", mem_req, 16'd0);
      check("rm_pc", pc, 16'h0000);
      check("rm_write", write, 16'd0);
      check("rm_wbmem", wb_mem, 16'd0);
      reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5103;
      tick();
      check("rm_fetch_req", mem_req, 16'd1);
      check("rm_fetch_addr", mem_addr, 16'h0000);
      check("rm_fetch_we", mem_we, 16'd0);
      exec3(16'h5103, 1'b1, 1'b0, 16'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
